// File: rtl/board_scan_reader_if.sv
// Beat stream from board_scan_reader: one square per valid/ready transfer.
interface board_scan_reader_if #(
    parameter int SQUARES = 64,
    parameter int PIECE_W = 4
);
    localparam int IDX_W = $clog2(SQUARES);

    logic               Out_Valid;
    logic               Out_Ready;
    logic [IDX_W-1:0]   Out_Index;
    logic [PIECE_W-1:0] Out_Piece;
    logic               Out_Last;

    modport master (output Out_Valid, Out_Index, Out_Piece, Out_Last, input Out_Ready);
    modport slave  (input Out_Valid, Out_Index, Out_Piece, Out_Last, output Out_Ready);
endinterface

// File: rtl/board_scan_reader.sv
// Snapshots the flat board on Start and streams it out one square per beat.
// Define SCAN_SKIP_EMPTY_EN to drop empty (code 0) squares from the stream.
module board_scan_reader #(
    parameter int SQUARES = 64,
    parameter int PIECE_W = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [SQUARES*PIECE_W-1:0] Board,
    board_scan_reader_if.master        scan,
    output logic                       Busy,
    output logic                       Done
);
    localparam int IDX_W = $clog2(SQUARES);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                          state;
    logic [SQUARES-1:0][PIECE_W-1:0] snap;
    logic [IDX_W-1:0]                idx;
    logic [PIECE_W-1:0]              piece;
    logic                            valid, last;

    logic [IDX_W-1:0]   start_idx, nxt_idx;
    logic [PIECE_W-1:0] start_piece;
    logic               start_any, start_last, nxt_last;

`ifdef SCAN_SKIP_EMPTY_EN
    logic [SQUARES-1:0][PIECE_W-1:0] brd_sq;
    logic [SQUARES-1:0]              occ_brd, occ_snap;
    logic [IDX_W-1:0]                brd_hi, snap_hi;

    assign brd_sq = Board;

    always_comb begin
        occ_brd   = '0;
        occ_snap  = '0;
        start_idx = '0;
        nxt_idx   = '0;
        brd_hi    = '0;
        snap_hi   = '0;
        start_any = 1'b0;
        for (int i = 0; i < SQUARES; i++) begin
            occ_brd[i]  = |brd_sq[i];
            occ_snap[i] = |snap[i];
        end
        // Descending walk: the lowest qualifying square is the last one written.
        for (int i = SQUARES - 1; i >= 0; i--) begin
            if (occ_brd[i]) start_idx = IDX_W'(i);
            if (occ_snap[i] && (IDX_W'(i) > idx)) nxt_idx = IDX_W'(i);
        end
        for (int i = 0; i < SQUARES; i++) begin
            if (occ_brd[i]) begin
                brd_hi    = IDX_W'(i);
                start_any = 1'b1;
            end
            if (occ_snap[i]) snap_hi = IDX_W'(i);
        end
    end

    assign start_piece = brd_sq[start_idx];
    assign start_last  = (start_idx == brd_hi);
    assign nxt_last    = (nxt_idx == snap_hi);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SQUARES - 1);

    assign start_any   = 1'b1;
    assign start_idx   = '0;
    assign start_piece = Board[PIECE_W-1:0];
    assign start_last  = 1'b0;
    assign nxt_idx     = idx + 1'b1;
    assign nxt_last    = (nxt_idx == LAST_IDX);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            snap  <= '0;
            idx   <= '0;
            piece <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (Start) begin
                    snap <= Board;
                    Busy <= 1'b1;
                    if (start_any) begin
                        state <= STREAM;
                        valid <= 1'b1;
                        idx   <= start_idx;
                        piece <= start_piece;
                        last  <= start_last;
                    end else begin
                        // Nothing to emit: go straight to the completion pulse.
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                STREAM: if (scan.Out_Ready) begin
                    if (last) begin
                        state <= DONE;
                        valid <= 1'b0;
                        last  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        idx   <= nxt_idx;
                        piece <= snap[nxt_idx];
                        last  <= nxt_last;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign scan.Out_Valid = valid;
    assign scan.Out_Index = idx;
    assign scan.Out_Piece = piece;
    assign scan.Out_Last  = last;
endmodule

// File: tb/tb_board_scan_reader.sv
// Directed bench for board_scan_reader; define SCAN_SKIP_EMPTY_EN to exercise skip mode.
module tb_board_scan_reader;
    localparam int SQUARES = 64;
    localparam int PIECE_W = 4;

    logic                       Clk = 1'b0;
    logic                       Reset, Start, Busy, Done;
    logic [SQUARES*PIECE_W-1:0] Board;

    board_scan_reader_if #(.SQUARES(SQUARES), .PIECE_W(PIECE_W)) bus();

    board_scan_reader #(.SQUARES(SQUARES), .PIECE_W(PIECE_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Board(Board),
        .scan(bus.master), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_pass = 0;
    int eidx[SQUARES];
    logic [PIECE_W-1:0] epc[SQUARES];
    int exp_n, nbeat, ndone, busy_falls, done_edge, cyc;
    int stall_at, poke_at, rst_at;
    bit poke_done, rewrite, busy_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Beat is scored before the edge it transfers on; DUT state is sampled 1ns after the edge.
    task automatic step();
        if (!Reset && bus.Out_Valid && bus.Out_Ready) begin
            if (nbeat < exp_n) begin
                chk("beat_idx", 32'(bus.Out_Index), 32'(eidx[nbeat]));
                chk("beat_piece", 32'(bus.Out_Piece), 32'(epc[eidx[nbeat]]));
                chk("beat_last", 32'(bus.Out_Last), (nbeat == exp_n - 1) ? 32'd1 : 32'd0);
            end
            nbeat++;
        end
        @(posedge Clk); #1;
        cyc++;
        // done_edge is the edge at which a consumer samples the pulse.
        if (Done) begin
            ndone++;
            if (done_edge < 0) done_edge = cyc + 1;
        end
        if (busy_q && !Busy) busy_falls++;
        busy_q = Busy;
    endtask

    task automatic knobs_clear();
        stall_at = -1; poke_at = -1; rst_at = -1; poke_done = 0; rewrite = 0;
    endtask

    task automatic set_board(input int mode);
        for (int i = 0; i < SQUARES; i++) begin
            epc[i] = (mode == 0) ? 4'(i % 16) : 4'(15 - (i % 16));
            Board[i*PIECE_W +: PIECE_W] = epc[i];
            eidx[i] = i;
        end
        exp_n = SQUARES;
    endtask

    task automatic run_scan(input int max_cyc);
        int  stall_left;
        bit  stalled;
        stall_left = 0; stalled = 0;
        nbeat = 0; ndone = 0; busy_falls = 0; done_edge = -1; cyc = -1; busy_q = Busy;
        Start = 1; step(); Start = 0;
        chk("first_valid", 32'(bus.Out_Valid), (exp_n > 0) ? 32'd1 : 32'd0);
        if (rewrite) Board = '1;
        for (int k = 0; k < max_cyc; k++) begin
            if (done_edge >= 0 && cyc >= done_edge + 3) break;
            if (bus.Out_Valid && int'(bus.Out_Index) == stall_at && !stalled) begin
                stall_left = 5; stalled = 1;
            end
            if (stall_left > 0) begin
                chk("stall_idx", 32'(bus.Out_Index), 32'(stall_at));
                chk("stall_piece", 32'(bus.Out_Piece), 32'(epc[stall_at]));
                bus.Out_Ready = 0; stall_left--;
            end else bus.Out_Ready = 1;
            Start = (bus.Out_Valid && int'(bus.Out_Index) == poke_at) || (Done && poke_done);
            if (bus.Out_Valid && int'(bus.Out_Index) == rst_at) begin
                Reset = 1; step(); Reset = 0; Start = 0; rst_at = -1;
                chk("rst_valid", 32'(bus.Out_Valid), 0);
                chk("rst_busy", 32'(Busy), 0);
                chk("rst_index", 32'(bus.Out_Index), 0);
                continue;
            end
            step();
        end
        Start = 0; bus.Out_Ready = 1;
    endtask

    initial begin
        Reset = 1; Start = 0; bus.Out_Ready = 1; Board = '0;
        knobs_clear();
        set_board(0);
        cyc = 0; nbeat = 0; ndone = 0; busy_falls = 0; busy_q = 0; done_edge = -1;
        repeat (2) begin @(posedge Clk); #1; end
        Reset = 0;
        chk("reset_valid", 32'(bus.Out_Valid), 0);
        chk("reset_busy", 32'(Busy), 0);
        chk("reset_done", 32'(Done), 0);
        chk("reset_index", 32'(bus.Out_Index), 0);
        chk("reset_piece", 32'(bus.Out_Piece), 0);
        chk("reset_last", 32'(bus.Out_Last), 0);

`ifdef SCAN_SKIP_EMPTY_EN
        Board = '0;
        for (int i = 0; i < SQUARES; i++) epc[i] = '0;
        epc[3] = 4'h2; epc[60] = 4'h9;
        Board[3*PIECE_W +: PIECE_W] = 4'h2;
        Board[60*PIECE_W +: PIECE_W] = 4'h9;
        eidx[0] = 3; eidx[1] = 60; exp_n = 2;
        run_scan(50);
        chk("sparse_beats", 32'(nbeat), 2);
        chk("sparse_done_edge", 32'(done_edge), 3);
        chk("sparse_ndone", 32'(ndone), 1);

        Board = '0; exp_n = 0;
        run_scan(50);
        chk("empty_beats", 32'(nbeat), 0);
        chk("empty_done_edge", 32'(done_edge), 1);
        chk("empty_ndone", 32'(ndone), 1);
        chk("empty_busy_end", 32'(Busy), 0);
`else
        // Full scan, ready held high.
        run_scan(200);
        chk("full_beats", 32'(nbeat), 64);
        chk("full_done_edge", 32'(done_edge), 65);
        chk("full_ndone", 32'(ndone), 1);
        chk("full_busy_falls", 32'(busy_falls), 1);

        // Backpressure at index 10 for 5 cycles.
        knobs_clear(); stall_at = 10;
        run_scan(200);
        chk("stall_beats", 32'(nbeat), 64);
        chk("stall_done_edge", 32'(done_edge), 70);

        // Board overwritten right after the snapshot edge.
        knobs_clear(); rewrite = 1;
        run_scan(200);
        chk("snap_beats", 32'(nbeat), 64);
        chk("snap_ndone", 32'(ndone), 1);

        // Start pokes during STREAM and DONE must be ignored.
        knobs_clear(); set_board(1); poke_at = 30; poke_done = 1;
        run_scan(200);
        chk("poke_beats", 32'(nbeat), 64);
        chk("poke_ndone", 32'(ndone), 1);
        chk("poke_busy_falls", 32'(busy_falls), 1);
        chk("poke_idle_valid", 32'(bus.Out_Valid), 0);
        chk("poke_idle_busy", 32'(Busy), 0);

        // Reset mid-scan abandons it; the next Start restarts at index 0.
        knobs_clear(); rst_at = 20;
        run_scan(100);
        chk("abort_beats", 32'(nbeat), 20);
        chk("abort_ndone", 32'(ndone), 0);
        knobs_clear(); set_board(0);
        run_scan(200);
        chk("restart_beats", 32'(nbeat), 64);
        chk("restart_done_edge", 32'(done_edge), 65);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
